// File: rtl/cpu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_fetch_ctrl
//
// Instruction fetch sequencer. It issues one word-aligned read at a time to
// instruction memory, forwards each returned word to the instruction FIFO,
// and handles branch redirects by flushing the FIFO and discarding any read
// that was already in flight.
//
// Ports
//   clk_i            rising-edge clock for all state
//   rst_i            synchronous reset, active low (0 = reset)
//   fetch_en_i       permits new memory requests while high
//   branch_i         one-cycle redirect strobe
//   branch_target_i  redirect byte address, bits [1:0] ignored
//   imem_req_o       instruction-memory read request
//   imem_addr_o      word-aligned read address, stable while imem_req_o
//   imem_ack_i       read complete, imem_data_i valid this cycle
//   imem_data_i      read data (big-endian, [31:16] is the first halfword)
//   fifo_full_i      instruction FIFO cannot accept another word
//   fifo_write_en_o  write strobe to the instruction FIFO
//   fifo_data_o      word to write
//   fifo_flush_o     one-cycle FIFO clear request, the cycle after a branch
//   fetch_pc_o       address of the next word to fetch
//
// Handshake: imem_req_o rises with imem_addr_o valid and both stay constant
// until the cycle imem_ack_i is seen high; only one read is ever in flight
// and imem_ack_i is ignored whenever imem_req_o is low.
// ---------------------------------------------------------------------------
module cpu_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h00001000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        fifo_full_i,
    output logic        fifo_write_en_o,
    output logic [31:0] fifo_data_o,
    output logic        fifo_flush_o,
    output logic [31:0] fetch_pc_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        flush_q, flush_d;

    logic [31:0] target_w;
    logic        start_fetch_w;

    assign target_w = {branch_target_i[31:2], 2'b00};

    // A branch in IDLE/HOLD only redirects the PC; the fetch from the new
    // target starts on a later cycle so it never overlaps the flush pulse.
    assign start_fetch_w = fetch_en_i && !fifo_full_i && !branch_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        data_d  = data_q;
        flush_d = branch_i;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (branch_i) begin
                    pc_d = target_w;
                end else if (start_fetch_w) begin
                    state_d = ST_FETCH;
                    addr_d  = pc_q;
                end
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    if (branch_i) begin
                        // Returned word belongs to the abandoned path.
                        pc_d    = target_w;
                        state_d = ST_HOLD;
                    end else begin
                        data_d  = imem_data_i;
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_WRITE;
                    end
                end else if (branch_i) begin
                    // Read is still in flight; wait it out in DRAIN.
                    pc_d    = target_w;
                    state_d = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                state_d = ST_HOLD;
                if (branch_i) begin
                    pc_d = target_w;
                end
            end
            ST_DRAIN: begin
                if (branch_i) begin
                    pc_d = target_w;
                end
                if (imem_ack_i) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            flush_q <= flush_d;
        end
    end

    assign imem_req_o  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem_addr_o = addr_q;

    // flush_q can never be set while in WRITE, but gating on it keeps the
    // write/flush exclusion local and obvious.
    assign fifo_write_en_o = (state_q == ST_WRITE) && !branch_i && !flush_q;
    assign fifo_data_o     = data_q;
    assign fifo_flush_o    = flush_q;
    assign fetch_pc_o      = pc_q;

endmodule
